// File: rtl/ice_tx_arbiter_pkg.sv
// Shared definitions for the ICE TX channel arbiter: FSM state encodings and
// the width of one TX character.
package ice_tx_arbiter_pkg;

  localparam int TX_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARB     = 2'd1,
    ST_XFER    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/ice_tx_arbiter_rr_priority_pick.sv
// Combinational round-robin pick: the first set request after the pointer
// position wins, found by rotating, priority-encoding and rotating back.
module rr_priority_pick
  import ice_tx_arbiter_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int PTR_W   = $clog2(NUM_DEV)
) (
  input  logic [NUM_DEV-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_DEV-1:0] winner,
  output logic               any
);

  logic [2*NUM_DEV-1:0] rot_wide;
  logic [2*NUM_DEV-1:0] pick_wide;
  logic [NUM_DEV-1:0]   rot;
  logic [NUM_DEV-1:0]   rot_pick;
  int                   shift;

  // Bit 0 of the rotated vector is the device just after the pointer, so the
  // lowest set bit is the highest-priority requester.
  always_comb begin
    shift    = int'(ptr) + 1;
    rot_wide = {req, req} >> shift;
    rot      = rot_wide[NUM_DEV-1:0];
    rot_pick = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (rot[i]) begin
        rot_pick    = '0;
        rot_pick[i] = 1'b1;
      end
    end
    pick_wide = {rot_pick, rot_pick} << shift;
    winner    = pick_wide[2*NUM_DEV-1:NUM_DEV];
    any       = |req;
  end

endmodule

// File: rtl/ice_tx_arbiter.sv
// Frame-level round-robin arbiter sharing the TX character channel among
// NUM_DEV devices, with a watchdog that evicts a stalled owner.
module ice_tx_arbiter
  import ice_tx_arbiter_pkg::*;
#(
  parameter int NUM_DEV = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_DEV-1:0]             req,
  input  logic [TX_BYTE_W*NUM_DEV-1:0]   dev_data,
  input  logic [NUM_DEV-1:0]             dev_valid,
  input  logic [NUM_DEV-1:0]             dev_last,
  output logic [NUM_DEV-1:0]             dev_latch,
  output logic [NUM_DEV-1:0]             grant,
  output logic [TX_BYTE_W-1:0]           tx_char,
  output logic                           tx_char_valid,
  input  logic                           tx_char_ready,
  output logic                           busy,
  output logic                           timeout_evt
);

  localparam int PTR_W = $clog2(NUM_DEV);

  arb_state_t         state, state_n;
  logic [NUM_DEV-1:0] grant_n;
  logic [NUM_DEV-1:0] winner;
  logic [PTR_W-1:0]   owner, owner_n;
  logic [PTR_W-1:0]   ptr, ptr_n;
  logic [PTR_W-1:0]   win_idx;
  logic [TO_W-1:0]    wdog, wdog_n, wdog_inc;
  logic               timeout_n;
  logic               any_req;
  logic               xfer_cycle;
  logic               transfer;
  logic               release_now;

  rr_priority_pick #(
    .NUM_DEV (NUM_DEV),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .winner (winner),
    .any    (any_req)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (winner[i]) win_idx = PTR_W'(i);
    end
  end

  // Gating with rst keeps a frame dropped by reset from consuming a byte.
  assign xfer_cycle    = (state == ST_XFER) && !rst;
  assign tx_char       = dev_data[owner*TX_BYTE_W +: TX_BYTE_W];
  assign tx_char_valid = xfer_cycle && dev_valid[owner];
  assign transfer      = tx_char_valid && tx_char_ready;
  assign dev_latch     = transfer ? grant : '0;
  assign busy          = (state != ST_IDLE);
  assign wdog_inc      = (wdog == '1) ? wdog : wdog + TO_W'(1);

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    owner_n     = owner;
    ptr_n       = ptr;
    wdog_n      = wdog;
    timeout_n   = 1'b0;
    release_now = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) state_n = ST_ARB;
      end
      ST_ARB: begin
        if (any_req) begin
          state_n = ST_XFER;
          grant_n = winner;
          owner_n = win_idx;
          wdog_n  = '0;
        end else begin
          state_n = ST_IDLE;
          grant_n = '0;
        end
      end
      ST_XFER: begin
        // A backpressured byte (valid, not ready) leaves the watchdog alone.
        if (transfer) begin
          if (dev_last[owner]) release_now = 1'b1;
          else                 wdog_n      = '0;
        end else if (!dev_valid[owner]) begin
          if (!req[owner]) begin
            release_now = 1'b1;
          end else if (wdog_inc == TO_W'(TIMEOUT)) begin
            release_now = 1'b1;
            timeout_n   = 1'b1;
            wdog_n      = wdog_inc;
          end else begin
            wdog_n = wdog_inc;
          end
        end
      end
      ST_RELEASE: begin
        state_n = ST_IDLE;
        grant_n = '0;
      end
      default: begin
        state_n = ST_IDLE;
        grant_n = '0;
      end
    endcase
    if (release_now) begin
      state_n = ST_RELEASE;
      grant_n = '0;
      ptr_n   = owner;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      owner       <= '0;
      ptr         <= PTR_W'(NUM_DEV - 1);
      wdog        <= '0;
      timeout_evt <= 1'b0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      owner       <= owner_n;
      ptr         <= ptr_n;
      wdog        <= wdog_n;
      timeout_evt <= timeout_n;
    end
  end

endmodule

// File: tb/tb_ice_tx_arbiter.sv
// Directed bench for ice_tx_arbiter: simple device models feed frames while a
// scoreboard holds the bytes the TX channel must carry, in order.
`timescale 1ns/1ps
module tb_ice_tx_arbiter;

  localparam int NUM_DEV = 4;
  localparam int TIMEOUT = 10;
  localparam int TO_W    = 8;

  typedef struct packed {
    logic [NUM_DEV-1:0] lat;
    logic [7:0]         data;
  } sb_item_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_DEV-1:0]   req;
  logic [8*NUM_DEV-1:0] dev_data;
  logic [NUM_DEV-1:0]   dev_valid;
  logic [NUM_DEV-1:0]   dev_last;
  logic [NUM_DEV-1:0]   dev_latch;
  logic [NUM_DEV-1:0]   grant;
  logic [7:0]           tx_char;
  logic                 tx_char_valid;
  logic                 tx_char_ready;
  logic                 busy;
  logic                 timeout_evt;

  int       compared     = 0;
  int       mismatched   = 0;
  int       timeout_seen = 0;
  sb_item_t sb[$];
  sb_item_t exp_item;

  logic [7:0] base     [NUM_DEV];
  int         len      [NUM_DEV];
  int         fr_start [NUM_DEV];
  int         cnt      [NUM_DEV];
  logic       dev_on   [NUM_DEV];

  logic [NUM_DEV-1:0] seen [5];
  logic [NUM_DEV-1:0] prev_grant;
  int                 gi;

  always #5 clk = ~clk;

  ice_tx_arbiter #(
    .NUM_DEV (NUM_DEV),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .dev_data      (dev_data),
    .dev_valid     (dev_valid),
    .dev_last      (dev_last),
    .dev_latch     (dev_latch),
    .grant         (grant),
    .tx_char       (tx_char),
    .tx_char_valid (tx_char_valid),
    .tx_char_ready (tx_char_ready),
    .busy          (busy),
    .timeout_evt   (timeout_evt)
  );

  // Each device counts consumed bytes; its current frame position is the
  // count since the frame was loaded.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_DEV; i++) begin
      if (dev_latch[i]) cnt[i] <= cnt[i] + 1;
    end
  end

  always_comb begin
    dev_valid = '0;
    dev_last  = '0;
    dev_data  = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      dev_valid[i]       = dev_on[i] && ((cnt[i] - fr_start[i]) < len[i]);
      dev_last[i]        = ((cnt[i] - fr_start[i]) == (len[i] - 1));
      dev_data[8*i +: 8] = base[i] + 8'(cnt[i] - fr_start[i]);
    end
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic load_frame(input int d, input logic [7:0] b, input int n,
                            input int npush);
    base[d]     = b;
    len[d]      = n;
    fr_start[d] = cnt[d];
    dev_on[d]   = 1'b1;
    for (int k = 0; k < npush; k++) begin
      sb.push_back('{lat: 4'(1 << d), data: b + 8'(k)});
    end
  endtask

  // Every TX transfer must match the next scoreboard entry; outside a
  // transfer no device may be told its byte was consumed.
  always @(negedge clk) begin
    if (timeout_evt) timeout_seen++;
    if (!rst) begin
      if (tx_char_valid && tx_char_ready) begin
        compared++;
        assert (sb.size() != 0) else begin
          mismatched++;
          $error("[TB] FAIL sb_unexpected_byte observed=%0h expected=none", tx_char);
        end
        if (sb.size() != 0) begin
          exp_item = sb.pop_front();
          check_output("sb_byte", 32'(tx_char), 32'(exp_item.data));
          check_output("sb_latch", 32'(dev_latch), 32'(exp_item.lat));
        end
      end else begin
        check_output("idle_latch", 32'(dev_latch), 32'd0);
      end
    end
  end

  initial begin
    rst           = 1'b1;
    req           = '0;
    tx_char_ready = 1'b1;
    prev_grant    = '0;
    gi            = 0;
    for (int i = 0; i < NUM_DEV; i++) begin
      base[i]     = '0;
      len[i]      = 0;
      fr_start[i] = 0;
      dev_on[i]   = 1'b0;
    end
    for (int i = 0; i < 5; i++) seen[i] = '0;

    // Reset values
    tick(3);
    check_output("rst_grant", 32'(grant), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_valid", 32'(tx_char_valid), 32'd0);
    check_output("rst_timeout", 32'(timeout_evt), 32'd0);
    check_output("rst_latch", 32'(dev_latch), 32'd0);
    rst = 1'b0;

    // Single device, 3-byte frame; req drops together with the last byte
    load_frame(1, 8'hA1, 3, 3);
    req = 4'b0010;
    tick(1);
    check_output("single_arb_grant", 32'(grant), 32'd0);
    check_output("single_arb_busy", 32'(busy), 32'd1);
    tick(1);
    check_output("single_grant", 32'(grant), 32'b0010);
    check_output("single_valid", 32'(tx_char_valid), 32'd1);
    tick(2);
    check_output("single_third_byte", 32'(tx_char), 32'hA3);
    req = '0;
    tick(1);
    check_output("single_release_grant", 32'(grant), 32'd0);
    check_output("single_release_busy", 32'(busy), 32'd1);
    check_output("single_release_gap", 32'(tx_char_valid), 32'd0);
    tick(1);
    check_output("single_idle_busy", 32'(busy), 32'd0);
    check_output("single_sb_empty", 32'(sb.size()), 32'd0);
    dev_on[1] = 1'b0;

    // Round robin with all requests held, 1-byte frames
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < NUM_DEV; i++) load_frame(i, 8'h10 * 8'(i + 1), 1, 1);
    req = 4'b1111;
    for (int c = 0; c < 40 && gi < 5; c++) begin
      tick(1);
      if (grant != '0 && prev_grant == '0) begin
        seen[gi] = grant;
        gi++;
        if (gi == 2) load_frame(0, 8'h50, 1, 1);
        if (gi == 5) req = '0;
      end
      prev_grant = grant;
    end
    check_output("rr_grant0", 32'(seen[0]), 32'b0001);
    check_output("rr_grant1", 32'(seen[1]), 32'b0010);
    check_output("rr_grant2", 32'(seen[2]), 32'b0100);
    check_output("rr_grant3", 32'(seen[3]), 32'b1000);
    check_output("rr_grant4", 32'(seen[4]), 32'b0001);
    tick(2);
    check_output("rr_done_busy", 32'(busy), 32'd0);
    check_output("rr_sb_empty", 32'(sb.size()), 32'd0);

    // Backpressure for 300 cycles must not trip the watchdog
    tx_char_ready = 1'b0;
    load_frame(2, 8'hC5, 1, 1);
    req = 4'b0100;
    tick(2);
    check_output("bp_grant", 32'(grant), 32'b0100);
    tick(300);
    check_output("bp_no_timeout", 32'(timeout_seen), 32'd0);
    check_output("bp_grant_held", 32'(grant), 32'b0100);
    check_output("bp_valid_held", 32'(tx_char_valid), 32'd1);
    tx_char_ready = 1'b1;
    tick(1);
    check_output("bp_release", 32'(grant), 32'd0);
    check_output("bp_sb_empty", 32'(sb.size()), 32'd0);
    req = '0;
    tick(1);

    // Watchdog: device 3 owns the channel but never sends
    load_frame(0, 8'h7E, 1, 1);
    dev_on[3] = 1'b0;
    req = 4'b1001;
    tick(2);
    check_output("wd_grant", 32'(grant), 32'b1000);
    tick(9);
    check_output("wd_not_yet", 32'(timeout_evt), 32'd0);
    check_output("wd_still_owner", 32'(grant), 32'b1000);
    tick(1);
    check_output("wd_evt", 32'(timeout_evt), 32'd1);
    check_output("wd_grant_cleared", 32'(grant), 32'd0);
    tick(1);
    check_output("wd_evt_one_cycle", 32'(timeout_evt), 32'd0);
    tick(2);
    check_output("wd_next_winner", 32'(grant), 32'b0001);
    req = '0;
    tick(2);
    check_output("wd_pulse_count", 32'(timeout_seen), 32'd1);
    check_output("wd_sb_empty", 32'(sb.size()), 32'd0);

    // Abandon: owner drops req with no byte pending
    load_frame(1, 8'hB0, 3, 1);
    load_frame(0, 8'h60, 1, 1);
    req = 4'b0011;
    tick(2);
    check_output("ab_grant", 32'(grant), 32'b0010);
    tick(1);
    dev_on[1] = 1'b0;
    req       = 4'b0001;
    tick(1);
    check_output("ab_release", 32'(grant), 32'd0);
    check_output("ab_busy", 32'(busy), 32'd1);
    check_output("ab_no_timeout", 32'(timeout_evt), 32'd0);
    req = 4'b0011;
    tick(3);
    check_output("ab_pointer_advanced", 32'(grant), 32'b0001);
    req = '0;
    tick(2);
    check_output("ab_sb_empty", 32'(sb.size()), 32'd0);
    check_output("ab_timeout_count", 32'(timeout_seen), 32'd1);

    // Reset in the middle of a 4-byte frame
    load_frame(1, 8'hD0, 4, 1);
    load_frame(0, 8'hE0, 1, 1);
    req = 4'b0011;
    tick(2);
    check_output("mr_grant", 32'(grant), 32'b0010);
    tick(1);
    check_output("mr_byte2_shown", 32'(tx_char), 32'hD1);
    rst = 1'b1;
    #1;
    check_output("mr_latch_in_reset", 32'(dev_latch), 32'd0);
    check_output("mr_valid_in_reset", 32'(tx_char_valid), 32'd0);
    tick(1);
    rst = 1'b0;
    check_output("mr_grant_after", 32'(grant), 32'd0);
    check_output("mr_busy_after", 32'(busy), 32'd0);
    check_output("mr_latch_after", 32'(dev_latch), 32'd0);
    tick(2);
    check_output("mr_dev0_first", 32'(grant), 32'b0001);
    req       = '0;
    dev_on[1] = 1'b0;
    tick(2);
    check_output("mr_sb_empty", 32'(sb.size()), 32'd0);
    check_output("mr_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
